// File: rtl/snn_event_pkg.sv
// Shared definitions for the spike event monitor: default sizes and the AER event record.
package snn_event_pkg;

  localparam int unsigned DefM     = 4;
  localparam int unsigned DefN     = 16;
  localparam int unsigned DefDepth = 8;

  // "time" is a keyword, so the timestamp field is named tstamp.
  typedef struct packed {
    logic [$clog2(DefM)-1:0] addr;
    logic [DefN-1:0]         tstamp;
  } spike_event_t;

endpackage

// File: rtl/sync_event_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty flags and a synchronous flush.
module sync_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // Push looks only at the registered full flag, so a same-cycle pop cannot make room.
  assign do_push = push & ~full_q & ~clear;
  assign do_pop  = pop & ~empty_q & ~clear;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
    if (clear) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (clear) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == (PW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = empty_q ? '0 : mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/spike_event_monitor.sv
// Timestamps per-step core spike flags and serialises them lowest-index-first into an event FIFO.
module spike_event_monitor
  import snn_event_pkg::*;
#(
  parameter int unsigned M     = DefM,
  parameter int unsigned N     = DefN,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned AW    = $clog2(M)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          apply,
  input  logic [M-1:0]  is_spiking,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [AW-1:0] ev_addr,
  output logic [N-1:0]  ev_time,
  output logic          overflow,
  output logic [N-1:0]  step_count
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [N-1:0]  tstamp;
  } ev_t;

  logic [N-1:0] step_q, step_d, stamp_q, stamp_d, pend_time_q, pend_time_d;
  logic [M-1:0] pending_q, pending_d, sel_onehot, residual;
  logic [AW-1:0] sel_idx;
  logic         apply_dly_q, overflow_q, overflow_d;
  logic         fifo_full, fifo_empty, push_en;
  ev_t          push_ev, head_ev;

  // Lowest set bit of pending wins.
  always_comb begin
    sel_idx    = '0;
    sel_onehot = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_idx       = AW'(i);
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
  end

  assign push_en  = (|pending_q) & ~fifo_full;
  assign residual = pending_q & ~(push_en ? sel_onehot : '0);

  always_comb begin
    step_d      = step_q;
    stamp_d     = stamp_q;
    pending_d   = residual;
    pend_time_d = pend_time_q;
    overflow_d  = overflow_q;
    if (apply) begin
      stamp_d = step_q;
      step_d  = step_q + 1'b1;
    end
    // A new sample replaces whatever the serialiser had not yet pushed.
    if (apply_dly_q) begin
      pending_d   = is_spiking;
      pend_time_d = stamp_q;
      if (|residual) overflow_d = 1'b1;
    end
    if (clear) begin
      step_d      = '0;
      stamp_d     = '0;
      pending_d   = '0;
      pend_time_d = '0;
      overflow_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q      <= '0;
      stamp_q     <= '0;
      apply_dly_q <= 1'b0;
      pending_q   <= '0;
      pend_time_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      step_q      <= step_d;
      stamp_q     <= stamp_d;
      apply_dly_q <= apply & ~clear;
      pending_q   <= pending_d;
      pend_time_q <= pend_time_d;
      overflow_q  <= overflow_d;
    end
  end

  assign push_ev.addr   = sel_idx;
  assign push_ev.tstamp = pend_time_q;

  sync_event_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(AW + N)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .push (push_en),
    .wdata(push_ev),
    .pop  (ev_ready),
    .rdata(head_ev),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign ev_valid   = ~fifo_empty;
  assign ev_addr    = head_ev.addr;
  assign ev_time    = head_ev.tstamp;
  assign overflow   = overflow_q;
  assign step_count = step_q;

endmodule

// File: tb/tb_spike_event_monitor.sv
// Scoreboard bench for spike_event_monitor: default instance plus an N=4 instance for wrap.
module tb_spike_event_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       apply = 1'b0;
  logic [3:0] is_spiking = '0;
  logic       ev_ready = 1'b0;

  logic        ev_valid, overflow;
  logic [1:0]  ev_addr;
  logic [15:0] ev_time, step_count;

  logic        ev_valid_w, overflow_w;
  logic [1:0]  ev_addr_w;
  logic [3:0]  ev_time_w, step_count_w;

  typedef struct {
    int addr;
    int tim;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spike_event_monitor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .apply     (apply),
    .is_spiking(is_spiking),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_addr   (ev_addr),
    .ev_time   (ev_time),
    .overflow  (overflow),
    .step_count(step_count)
  );

  spike_event_monitor #(.N(4)) dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .apply     (apply),
    .is_spiking(is_spiking),
    .ev_valid  (ev_valid_w),
    .ev_ready  (ev_ready),
    .ev_addr   (ev_addr_w),
    .ev_time   (ev_time_w),
    .overflow  (overflow_w),
    .step_count(step_count_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply      = 1'b0;
    clear      = 1'b0;
    is_spiking = '0;
    ev_ready   = 1'b0;
    rst_n      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    sb.delete();
  endtask

  // One apply strobe carrying a spike pattern; returns two edges later (pending loaded).
  task automatic strobe(input logic [3:0] pat);
    apply      = 1'b1;
    is_spiking = pat;
    tick();
    apply = 1'b0;
    tick();
    is_spiking = '0;
  endtask

  task automatic drain(input int n, input int budget);
    exp_t e;
    int   got;
    got      = 0;
    ev_ready = 1'b1;
    for (int c = 0; c < budget && got < n; c++) begin
      if (ev_valid) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL drain_extra: got addr=%0d time=%0d, required no event", ev_addr, ev_time);
        end else begin
          e = sb.pop_front();
          if (ev_addr !== 2'(e.addr) || ev_time !== 16'(e.tim)) begin
            errors++;
            $display("FAIL drain_event: got addr=%0d time=%0d, required addr=%0d time=%0d",
                     ev_addr, ev_time, e.addr, e.tim);
          end
        end
        got++;
      end
      tick();
    end
    vectors++;
    if (got != n) begin
      errors++;
      $display("FAIL drain_count: got %0d events, required %0d", got, n);
    end
    vectors++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: ev_valid=%b, required 0", ev_valid);
    end
    ev_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply      = 1'($urandom_range(0, 1));
      clear      = 1'($urandom_range(0, 1));
      ev_ready   = 1'($urandom_range(0, 1));
      is_spiking = 4'($urandom);
      tick();
      vectors++;
      if ({ev_valid, ev_addr, ev_time, overflow, step_count} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: valid=%b addr=%0d time=%0d ovf=%b step=%0d, required all 0",
                 ev_valid, ev_addr, ev_time, overflow, step_count);
      end
    end
    apply = 1'b0; clear = 1'b0; ev_ready = 1'b0; is_spiking = '0;
    rst_n = 1'b1;
    seen  = 1'b0;
    apply = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen |= ev_valid;
    end
    apply = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen |= ev_valid;
    end
    vectors++;
    if (step_count !== 16'd5) begin
      errors++;
      $display("FAIL reset_steps: step_count=%0d, required 5", step_count);
    end
    vectors++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_event: ev_valid rose=%b, required 0", seen);
    end
  endtask

  task automatic test_simultaneous();
    ev_ready = 1'b1;
    sb.push_back('{0, 5});
    sb.push_back('{1, 5});
    sb.push_back('{3, 5});
    strobe(4'b1011);
    vectors++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_latency: ev_valid=%b after E1, required 0", ev_valid);
    end
    tick();
    drain(3, 3);
  endtask

  task automatic test_single();
    do_reset();
    sb.push_back('{2, 0});
    strobe(4'b0100);
    vectors++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: ev_valid=%b after E1, required 0", ev_valid);
    end
    tick();
    vectors++;
    if (ev_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_valid: ev_valid=%b after E2, required 1", ev_valid);
    end
    drain(1, 5);
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int s = 0; s < 4; s++) begin
      if (s != 2) begin
        for (int a = 0; a < 4; a++) sb.push_back('{a, s});
      end
      strobe(4'b1111);
      for (int i = 0; i < 6; i++) tick();
    end
    vectors++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_overflow: overflow=%b, required 1", overflow);
    end
    drain(12, 40);
    vectors++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_sticky: overflow=%b after drain, required 1", overflow);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) strobe(4'b0000);
    strobe(4'b0010);
    tick();
    vectors++;
    if (ev_valid_w !== 1'b1 || ev_addr_w !== 2'd1 || ev_time_w !== 4'd0) begin
      errors++;
      $display("FAIL wrap_event: valid=%b addr=%0d time=%0d, required 1/1/0",
               ev_valid_w, ev_addr_w, ev_time_w);
    end
    vectors++;
    if (ev_valid !== 1'b1 || ev_time !== 16'd16) begin
      errors++;
      $display("FAIL wide_event: valid=%b time=%0d, required 1/16", ev_valid, ev_time);
    end
    vectors++;
    if (step_count_w !== 4'd1) begin
      errors++;
      $display("FAIL wrap_steps: step_count=%0d, required 1", step_count_w);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    strobe(4'b0111);
    tick();
    tick();
    tick();
    vectors++;
    if (ev_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: ev_valid=%b with events queued, required 1", ev_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (ev_valid !== 1'b0 || ev_addr !== 2'd0 || ev_time !== 16'd0 || step_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_async: valid=%b addr=%0d time=%0d step=%0d, required all 0",
               ev_valid, ev_addr, ev_time, step_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clear_mid_drain();
    do_reset();
    apply      = 1'b1;
    is_spiking = 4'b0111;
    tick();
    tick();
    apply = 1'b0;
    tick();
    is_spiking = '0;
    vectors++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL clr_collision: overflow=%b, required 1", overflow);
    end
    tick();
    tick();
    tick();
    vectors++;
    if (ev_valid !== 1'b1 || step_count !== 16'd2) begin
      errors++;
      $display("FAIL clr_pre: valid=%b step=%0d, required 1/2", ev_valid, step_count);
    end
    clear = 1'b1;
    apply = 1'b1;
    tick();
    clear = 1'b0;
    apply = 1'b0;
    vectors++;
    if (ev_valid !== 1'b0 || overflow !== 1'b0 || step_count !== 16'd0) begin
      errors++;
      $display("FAIL clr_state: valid=%b ovf=%b step=%0d, required 0/0/0",
               ev_valid, overflow, step_count);
    end
    tick();
    tick();
    vectors++;
    if (ev_valid !== 1'b0 || step_count !== 16'd0) begin
      errors++;
      $display("FAIL clr_settled: valid=%b step=%0d, required 0/0", ev_valid, step_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_simultaneous();
    test_single();
    test_backpressure();
    test_wrap();
    test_reset_mid_drain();
    test_clear_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
